// File: rtl/wired_div_arb_if.sv
// Bundles the request ports, the result port and the external divider link
// of wired_div_arb.
//
// Handshake rule for both request and result channels: a transfer happens on
// a rising clk edge where valid and ready are both 1. Once valid is raised,
// the driver keeps valid and its payload unchanged until that transfer.
// Ready may depend on valid in the same cycle.
interface wired_div_arb_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_op;
    logic [7:0]  req_tag;
    logic        flush;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_port;
    logic [3:0]  out_tag;

    logic        div_start;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_sign;
    logic        div_busy;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    logic [1:0]  dbg_state;

    modport master (
        output req_valid, req_a, req_b, req_op, req_tag, flush, out_ready,
               div_busy, div_quo, div_rem,
        input  req_ready, out_valid, out_data, out_port, out_tag,
               div_start, div_a, div_b, div_sign, dbg_state
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_tag, flush, out_ready,
               div_busy, div_quo, div_rem,
        output req_ready, out_valid, out_data, out_port, out_tag,
               div_start, div_a, div_b, div_sign, dbg_state
    );
endinterface

// File: rtl/wired_div_arb.sv
// Two-port round-robin front end for a shared 32-iteration divider.
// Divide-by-zero and signed INT_MIN / -1 are answered locally in one cycle;
// every other operation is launched on the external divider and its result
// is held on the output port until consumed.
module wired_div_arb (
    input  logic            clk,
    input  logic            rst_n,
    wired_div_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Operands and routing info of the operation in flight
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic        sign_r;
    logic        rem_sel_r;
    logic        port_r;
    logic [3:0]  tag_r;
    logic        last_grant;
    logic [31:0] out_data_r;

    // Arbitration / fast-path decode
    logic        gnt_port;
    logic        accept;
    logic [1:0]  grant;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [1:0]  sel_op;
    logic [3:0]  sel_tag;
    logic        fast_zero;
    logic        fast_ovf;
    logic        fast;
    logic [31:0] fast_data;

    // Round-robin pick, operand mux and fast-path result for the winning port
    always_comb begin
        gnt_port  = 1'b0;
        grant     = 2'b00;
        fast_data = 32'd0;

        if (bus.req_valid == 2'b11) begin
            gnt_port = ~last_grant;
        end else begin
            gnt_port = bus.req_valid[1];
        end

        sel_a   = gnt_port ? bus.req_a[63:32]  : bus.req_a[31:0];
        sel_b   = gnt_port ? bus.req_b[63:32]  : bus.req_b[31:0];
        sel_op  = gnt_port ? bus.req_op[3:2]   : bus.req_op[1:0];
        sel_tag = gnt_port ? bus.req_tag[7:4]  : bus.req_tag[3:0];

        // Flush and reset both veto acceptance in the cycle they are seen
        accept = rst_n && !bus.flush && (state == IDLE) && (bus.req_valid != 2'b00);
        if (accept) begin
            grant = gnt_port ? 2'b10 : 2'b01;
        end

        fast_zero = (sel_b == 32'd0);
        fast_ovf  = sel_op[0] && (sel_a == 32'h8000_0000) && (sel_b == 32'hFFFF_FFFF);
        fast      = fast_zero || fast_ovf;

        if (fast_zero) begin
            fast_data = sel_op[1] ? sel_a : 32'hFFFF_FFFF;
        end else if (fast_ovf) begin
            fast_data = sel_op[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // Next-state logic; flush overrides everything else
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = fast ? DONE : LAUNCH;
                end
            end
            LAUNCH: begin
                // div_busy is not yet meaningful for the new operation here
                state_nxt = WAIT;
            end
            WAIT: begin
                if (!bus.div_busy) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) begin
            state_nxt = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture on accept, result capture on fast path or divider done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r        <= 32'd0;
            b_r        <= 32'd0;
            sign_r     <= 1'b0;
            rem_sel_r  <= 1'b0;
            port_r     <= 1'b0;
            tag_r      <= 4'd0;
            last_grant <= 1'b1;
            out_data_r <= 32'd0;
        end else begin
            if (accept) begin
                a_r        <= sel_a;
                b_r        <= sel_b;
                sign_r     <= sel_op[0];
                rem_sel_r  <= sel_op[1];
                port_r     <= gnt_port;
                tag_r      <= sel_tag;
                last_grant <= gnt_port;
                if (fast) begin
                    out_data_r <= fast_data;
                end
            end else if ((state == WAIT) && !bus.div_busy && !bus.flush) begin
                out_data_r <= rem_sel_r ? bus.div_rem : bus.div_quo;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = out_data_r;
    assign bus.out_port  = port_r;
    assign bus.out_tag   = tag_r;
    // Operand registers only change on accept, so the divider inputs stay
    // stable for the whole LAUNCH..WAIT window.
    assign bus.div_start = (state == LAUNCH);
    assign bus.div_a     = a_r;
    assign bus.div_b     = b_r;
    assign bus.div_sign  = sign_r;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_wired_div_arb.sv
// Bench for wired_div_arb: directed scenarios followed by random traffic,
// with a behavioural divider stub and a result scoreboard.
module tb_wired_div_arb;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wired_div_arb_if bus ();

    wired_div_arb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic exp_last;                   // model of the last-granted port
    logic [36:0] exp_q[$];            // {port, tag, data}

    // ---------------- reference arithmetic ----------------
    function automatic logic [63:0] arith_div(logic [31:0] a, logic [31:0] b, logic sgn);
        int sa;
        int sb;
        if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
            return {2{32'h0BAD_0BAD}};
        end
        if (sgn) begin
            sa = a;
            sb = b;
            return {32'(sa / sb), 32'(sa % sb)};
        end
        return {a / b, a % b};
    endfunction

    function automatic logic [31:0] ref_result(logic [31:0] a, logic [31:0] b, logic [1:0] op);
        logic [63:0] qr;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        qr = arith_div(a, b, op[0]);
        return op[1] ? qr[31:0] : qr[63:32];
    endfunction

    // ---------------- divider stub ----------------
    logic [5:0]  stub_cnt;
    logic [31:0] stub_quo;
    logic [31:0] stub_rem;
    logic        stub_busy;

    always @(posedge clk) begin
        if (!rst_n) begin
            stub_cnt <= 6'd0;
        end else if (bus.div_start) begin
            stub_cnt <= 6'd1;
            {stub_quo, stub_rem} <= arith_div(bus.div_a, bus.div_b, bus.div_sign);
        end else if (stub_cnt != 6'd0 && stub_cnt < 6'd33) begin
            stub_cnt <= stub_cnt + 6'd1;
        end else begin
            stub_cnt <= 6'd0;
        end
    end

    assign stub_busy    = (stub_cnt >= 6'd1) && (stub_cnt <= 6'd32);
    assign bus.div_busy = stub_busy;
    assign bus.div_quo  = stub_busy ? 32'hDEAD_BEEF : stub_quo;
    assign bus.div_rem  = stub_busy ? 32'hDEAD_BEEF : stub_rem;

    // ---------------- divider-side monitor ----------------
    int          n_starts = 0;
    int          mon_err  = 0;
    logic        in_div   = 1'b0;
    logic [32:0] held_ops;
    logic [31:0] held_b;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_div = 1'b0;
        end else begin
            if (in_div && ({bus.div_sign, bus.div_a} !== held_ops || bus.div_b !== held_b)) begin
                mon_err++;
            end
            if (in_div && bus.div_start) mon_err++;   // start lasting more than one cycle
            if (bus.out_valid || bus.flush) in_div = 1'b0;
            if (bus.div_start) begin
                n_starts++;
                in_div   = 1'b1;
                held_ops = {bus.div_sign, bus.div_a};
                held_b   = bus.div_b;
            end
        end
    end

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        rst_n         = 1'b0;
        bus.req_valid = 2'b00;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        rst_n    = 1'b1;
        exp_last = 1'b1;
        exp_q.delete();
    endtask

    task automatic drive_req(input logic [1:0] mask,
                             input logic [31:0] a0, input logic [31:0] b0,
                             input logic [1:0] op0, input logic [3:0] tag0,
                             input logic [31:0] a1, input logic [31:0] b1,
                             input logic [1:0] op1, input logic [3:0] tag1);
        bus.req_valid = mask;
        bus.req_a     = {a1, a0};
        bus.req_b     = {b1, b0};
        bus.req_op    = {op1, op0};
        bus.req_tag   = {tag1, tag0};
        #1;
    endtask

    // Waits for a grant, checks it against the round-robin model, then
    // follows the operation to completion and consumes the result.
    task automatic run_txn(input string name, input logic [1:0] mask,
                           input logic [31:0] a0, input logic [31:0] b0,
                           input logic [1:0] op0, input logic [3:0] tag0,
                           input logic [31:0] a1, input logic [31:0] b1,
                           input logic [1:0] op1, input logic [3:0] tag1,
                           input int hold);
        int          waitc;
        int          lat;
        int          starts0;
        logic        eg;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [1:0]  eop;
        logic        fastp;
        logic        stable_ok;
        logic [37:0] snap;
        logic [36:0] exp;

        drive_req(mask, a0, b0, op0, tag0, a1, b1, op1, tag1);
        waitc = 0;
        while (bus.req_ready == 2'b00 && waitc < 50) begin
            tick();
            #1;
            waitc++;
        end
        eg = (mask == 2'b11) ? ~exp_last : mask[1];
        check({name, "_grant"}, bus.req_ready, eg ? 2'b10 : 2'b01);
        if (bus.req_ready == 2'b00) begin
            bus.req_valid = 2'b00;
            return;
        end
        exp_last = eg;
        ea    = eg ? a1 : a0;
        eb    = eg ? b1 : b0;
        eop   = eg ? op1 : op0;
        fastp = (eb == 32'd0) || (eop[0] && ea == 32'h8000_0000 && eb == 32'hFFFF_FFFF);
        exp_q.push_back({eg, eg ? tag1 : tag0, ref_result(ea, eb, eop)});
        starts0 = n_starts;

        tick();                                   // cycle T+1
        bus.req_valid = 2'b00;
        check({name, "_start"}, bus.div_start, !fastp);
        if (!fastp) begin
            check({name, "_div_ops"}, {bus.div_sign, bus.div_a, bus.div_b}, {eop[0], ea, eb});
        end

        lat = 1;
        while (!bus.out_valid && lat < 60) begin
            tick();
            lat++;
        end
        check({name, "_lat"}, lat, fastp ? 1 : 35);

        snap      = {bus.out_valid, bus.out_port, bus.out_tag, bus.out_data};
        stable_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 2'b11;
            #1;
            if (bus.req_ready !== 2'b00) stable_ok = 1'b0;
            tick();
            if ({bus.out_valid, bus.out_port, bus.out_tag, bus.out_data} !== snap) stable_ok = 1'b0;
        end
        bus.req_valid = 2'b00;
        if (hold > 0) check({name, "_hold"}, stable_ok, 1'b1);

        exp = exp_q.pop_front();
        check({name, "_result"}, {bus.out_port, bus.out_tag, bus.out_data}, exp);
        check({name, "_nstart"}, n_starts - starts0, fastp ? 0 : 1);

        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({name, "_release"}, bus.out_valid, 1'b0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [1:0]  mask;
        logic [31:0] ra [2];
        logic [31:0] rb [2];
        logic [1:0]  rop [2];
        int          r;
        int          waitc;

        bus.req_valid = 2'b00;
        bus.req_a     = 64'd0;
        bus.req_b     = 64'd0;
        bus.req_op    = 4'd0;
        bus.req_tag   = 8'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset: no grant while rst_n is low, outputs cleared afterwards
        rst_n = 1'b0;
        tick();
        drive_req(2'b11, 32'd1, 32'd1, 2'b00, 4'd1, 32'd2, 32'd1, 2'b00, 4'd2);
        check("rst_ready", bus.req_ready, 2'b00);
        tick();
        bus.req_valid = 2'b00;
        rst_n    = 1'b1;
        exp_last = 1'b1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_fields", {bus.out_port, bus.out_tag, bus.out_data}, 37'd0);
        check("rst_div_start", bus.div_start, 1'b0);

        // Basic divides
        run_txn("u_quo", 2'b01, 32'd100, 32'd7, 2'b00, 4'd3, 32'd0, 32'd0, 2'b00, 4'd0, 0);
        run_txn("s_rem", 2'b10, 32'd0, 32'd0, 2'b00, 4'd0, 32'hFFFF_FF9C, 32'd7, 2'b11, 4'd9, 0);
        run_txn("s_quo", 2'b01, 32'hFFFF_FF9C, 32'd7, 2'b01, 4'd4, 32'd0, 32'd0, 2'b00, 4'd0, 0);

        // Fast paths and the unsigned look-alike of INT_MIN / -1
        run_txn("z_quo", 2'b01, 32'd5, 32'd0, 2'b00, 4'd6, 32'd0, 32'd0, 2'b00, 4'd0, 0);
        run_txn("z_rem", 2'b10, 32'd0, 32'd0, 2'b00, 4'd0, 32'd5, 32'd0, 2'b10, 4'd7, 0);
        run_txn("ovf_quo", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 2'b01, 4'd8, 32'd0, 32'd0, 2'b00, 4'd0, 0);
        run_txn("ovf_rem", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 4'd8, 32'd0, 32'd0, 2'b00, 4'd0, 0);
        run_txn("uovf_quo", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 4'd2, 32'd0, 32'd0, 2'b00, 4'd0, 0);

        // Round robin from reset: port0, port1, port0, ...
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            run_txn("rr", 2'b11, 32'(i), 32'd0, 2'b10, 4'(i), 32'(i + 10), 32'd0, 2'b10, 4'(i + 8), 0);
        end

        // Output back-pressure for 20 cycles, then IDLE on the very next cycle
        run_txn("bp", 2'b01, 32'd1000, 32'd9, 2'b00, 4'd5, 32'd0, 32'd0, 2'b00, 4'd0, 20);
        drive_req(2'b01, 32'd1, 32'd0, 2'b00, 4'd1, 32'd0, 32'd0, 2'b00, 4'd0);
        check("bp_idle_next", bus.req_ready, 2'b01);
        bus.req_valid = 2'b00;

        // Flush blocks acceptance in IDLE
        drive_req(2'b11, 32'd4, 32'd2, 2'b00, 4'd1, 32'd4, 32'd2, 2'b00, 4'd2);
        bus.flush = 1'b1;
        #1;
        check("flush_no_grant", bus.req_ready, 2'b00);
        tick();
        bus.flush     = 1'b0;
        bus.req_valid = 2'b00;

        // Flush a divide at T+10, new request at T+12
        drive_req(2'b01, 32'd1000, 32'd3, 2'b00, 4'd5, 32'd0, 32'd0, 2'b00, 4'd0);
        waitc = 0;
        while (bus.req_ready == 2'b00 && waitc < 50) begin
            tick();
            #1;
            waitc++;
        end
        check("fl_grant", bus.req_ready, 2'b01);
        exp_last = 1'b0;
        tick();                                   // T+1
        bus.req_valid = 2'b00;
        repeat (9) tick();                        // T+10
        bus.flush = 1'b1;
        tick();                                   // T+11
        bus.flush = 1'b0;
        check("fl_out_valid", bus.out_valid, 1'b0);
        tick();                                   // T+12
        run_txn("fl_next", 2'b01, 32'd9, 32'd3, 2'b00, 4'd11, 32'd0, 32'd0, 2'b00, 4'd0, 0);

        // Flush has priority over the output handshake in DONE
        drive_req(2'b10, 32'd0, 32'd0, 2'b00, 4'd0, 32'd7, 32'd0, 2'b00, 4'd3);
        tick();
        bus.req_valid = 2'b00;
        check("fd_valid", bus.out_valid, 1'b1);
        exp_last      = 1'b1;
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        check("fd_dropped", bus.out_valid, 1'b0);

        // Reset mid-divide abandons the operation and restores the pointer
        drive_req(2'b01, 32'd77, 32'd5, 2'b00, 4'd12, 32'd0, 32'd0, 2'b00, 4'd0);
        tick();
        bus.req_valid = 2'b00;
        repeat (5) tick();
        reset_dut();
        check("mr_out", {bus.out_valid, bus.out_port, bus.out_tag, bus.out_data}, 38'd0);
        repeat (40) tick();
        check("mr_no_result", bus.out_valid, 1'b0);
        run_txn("mr_rr", 2'b11, 32'd50, 32'd5, 2'b00, 4'd1, 32'd60, 32'd6, 2'b00, 4'd2, 0);

        // Random traffic
        for (int n = 0; n < 25; n++) begin
            mask = 2'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++) begin
                r = $urandom_range(0, 9);
                ra[p]  = $urandom;
                rop[p] = 2'($urandom_range(0, 3));
                if (r == 0) begin
                    rb[p] = 32'd0;
                end else if (r == 1) begin
                    ra[p]  = 32'h8000_0000;
                    rb[p]  = 32'hFFFF_FFFF;
                    rop[p][0] = 1'b1;
                end else if (r < 6) begin
                    rb[p] = $urandom_range(1, 1000);
                end else begin
                    rb[p] = $urandom;
                end
            end
            run_txn("rnd", mask, ra[0], rb[0], rop[0], 4'($urandom_range(0, 15)),
                    ra[1], rb[1], rop[1], 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3));
        end

        check("div_if_stable", mon_err, 0);
        check("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wired_div_arb.md
WIRED_DIV_ARB -- requirements
Module: wired_div_arb

Interface
REQ-001 SHALL have: clk  in  1  clock, all state updates on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: req_valid  in  2  per-port request valid, bit i = port i.
REQ-004 SHALL have: req_ready  out  2  per-port request accept.
REQ-005 SHALL have: req_a  in  64  dividends, {port1, port0}.
REQ-006 SHALL have: req_b  in  64  divisors, {port1, port0}.
REQ-007 SHALL have: req_op  in  4  per port 2 bits {rem_sel, sign}: rem_sel=1 returns remainder, else quotient; sign=1 signed.
REQ-008 SHALL have: req_tag  in  8  per-port 4-bit tag, {port1, port0}.
REQ-009 SHALL have: flush  in  1  abort current operation, drop result.
REQ-010 SHALL have: out_valid  out  1; out_ready  in  1; out_data  out  32; out_port  out  1; out_tag  out  4.
REQ-011 SHALL have divider side: div_start out 1, div_a out 32, div_b out 32, div_sign out 1, div_busy in 1, div_quo in 32, div_rem in 32 (fixed 32-iteration divider, busy rises cycle after start, drops 33 cycles after start).

Function
REQ-012 SHALL implement states IDLE, LAUNCH, WAIT, DONE.
REQ-013 req_ready SHALL be nonzero only in IDLE with flush=0, one-hot, granting one valid port.
REQ-014 Arbitration SHALL be round-robin: both valid -> grant port not granted last; one valid -> grant it; last-grant pointer updates only on accept.
REQ-015 Accept (cycle T) SHALL register a, b, op, tag, port.
REQ-016 Fast path: b==0 -> DONE at T+1, quo=32'hFFFFFFFF, rem=a; no div_start.
REQ-017 Fast path: sign=1, a==32'h80000000, b==32'hFFFFFFFF -> DONE at T+1, quo=32'h80000000, rem=0; no div_start.
REQ-018 Otherwise IDLE->LAUNCH; in LAUNCH div_start=1 for exactly one cycle (T+1), div_a/div_b/div_sign from registered operands, then ->WAIT.
REQ-019 div_a, div_b, div_sign SHALL remain stable from LAUNCH until leaving WAIT.
REQ-020 WAIT SHALL ignore div_busy in LAUNCH cycle; in WAIT, first cycle div_busy=0 (T+34) SHALL capture div_quo or div_rem per rem_sel into output register, ->DONE; out_valid=1 from T+35.
REQ-021 DONE SHALL hold out_valid, out_data, out_port, out_tag stable until out_valid&out_ready; then ->IDLE next cycle.
REQ-022 No new request SHALL be accepted in the cycle DONE completes; earliest next accept is the following IDLE cycle.
REQ-023 flush=1 in any state SHALL force IDLE next cycle, out_valid=0 next cycle, no result emitted; flush has priority over accept and out handshake.
REQ-024 Flushed in-flight divider operation SHALL be overridden by next div_start; stale div_busy SHALL not affect the new operation (guaranteed by REQ-020).
REQ-025 div_start SHALL never assert outside LAUNCH.

Reset
REQ-026 rst_n=0 at a clock edge SHALL give: state IDLE, req_ready=0 that cycle, out_valid=0, div_start=0, out_data=0, out_port=0, out_tag=0, last-grant pointer=1 (port0 wins first tie).
REQ-027 Reset mid-operation SHALL abandon the operation with no output, same as REQ-026.

Verification
REQ-028 Port0 a=100,b=7,op=unsigned quo, tag=3 -> div_start at T+1, out_valid at T+35, out_data=14, out_port=0, out_tag=3.
REQ-029 Port1 a=-100,b=7,signed rem -> out_data=32'hFFFFFFFE (-2), out_port=1.
REQ-030 Both ports valid continuously after reset -> grants port0, port1, port0, ... alternating.
REQ-031 b=0, a=5 quo -> out_valid at T+1, out_data=32'hFFFFFFFF, no div_start; a=32'h80000000,b=-1 signed quo -> 32'h80000000 at T+1.
REQ-032 flush at T+10 of a divide, new request accepted at T+12 (a=9,b=3 quo) -> no output for first, second returns 3 at its T+35.
REQ-033 out_ready=0 for 20 cycles in DONE -> outputs stable, req_ready=0 throughout; out_ready=1 -> handshake, IDLE next cycle.
